// File: rtl/imem_loader.sv
// Boot loader: streams a 4-byte big-endian length header plus payload into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before releasing the CPU.
module imem_loader #(
  parameter int ADDRESS_WIDTH = 20,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic                     we,
  output logic [ADDRESS_WIDTH-1:0] WA,
  output logic [DATA_WIDTH-1:0]    WD,
  output logic                     done,
  output logic                     err,
  output logic                     cpu_rst_n
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
  localparam state_t S_END = S_CHK;
`else
  typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_END = S_DONE;
`endif

  // Largest image that still fits the address space; LEN may equal it exactly.
  localparam logic [32:0] LEN_MAX = 33'd1 << ADDRESS_WIDTH;

  state_t                   state_q, state_d;
  logic [31:0]              len_q, len_d;
  logic [1:0]               hcnt_q, hcnt_d;
  logic [31:0]              cnt_q, cnt_d;
  logic                     rx_ready_q, rx_ready_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0]    wd_q, wd_d;
  logic                     cpu_rst_n_q, cpu_rst_n_d;
  logic                     accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]               csum_q, csum_d;
`endif

  assign accept = rx_valid & rx_ready_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hcnt_d      = hcnt_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    wa_d        = wa_q;
    wd_d        = wd_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_HDR: begin
        if (accept) begin
          len_d  = {len_q[23:0], rx_data};
          hcnt_d = hcnt_q + 2'd1;
          if (hcnt_q == 2'd3) begin
            if ({1'b0, len_d} > LEN_MAX) state_d = S_ERR;
            else if (len_d == 32'd0)     state_d = S_END;
            else                         state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          we_d  = 1'b1;
          wa_d  = cnt_q[ADDRESS_WIDTH-1:0];
          wd_d  = rx_data;
          cnt_d = cnt_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (cnt_q + 32'd1 == len_q) state_d = S_END;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        // csum_q already holds the XOR of every payload byte.
        if (accept) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: ;
    endcase
    // Ready follows the next state so the source is refused as soon as loading ends.
    rx_ready_d  = (state_d != S_DONE) && (state_d != S_ERR);
    cpu_rst_n_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HDR;
      len_q       <= '0;
      hcnt_q      <= '0;
      cnt_q       <= '0;
      rx_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      cpu_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hcnt_q      <= hcnt_d;
      cnt_q       <= cnt_d;
      rx_ready_q  <= rx_ready_d;
      we_q        <= we_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rx_ready  = rx_ready_q;
  assign we        = we_q;
  assign WA        = wa_q;
  assign WD        = wd_q;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: byte streams with random stalls are checked
// against a length/checksum reference model of the boot image format.
module tb_imem_loader;
  localparam int AW = 20;
  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, we, done, err, cpu_rst_n;
  logic [AW-1:0] WA;
  logic [7:0]    WD;

  imem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .we(we), .WA(WA), .WD(WD),
    .done(done), .err(err), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed writes, captured mid-cycle.
  logic [AW+7:0] wq[$];
  int cyc = 0;
  int done_cyc = -1;
  int cpu_cyc = -1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (we) wq.push_back({WA, WD});
    if (done && done_cyc < 0) done_cyc = cyc;
    if (cpu_rst_n && cpu_rst_n_cyc_unset()) cpu_cyc = cyc;
  end

  function automatic bit cpu_rst_n_cyc_unset();
    return cpu_cyc < 0;
  endfunction

  // Reference model: the image format expressed directly as arithmetic on the stream.
  logic [AW+7:0] exp_wq[$];
  bit exp_done, exp_err;

  function automatic void run_model(input bq_t s);
    logic [63:0] len;
    logic [7:0]  x;
    exp_wq.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (s.size() < 4) return;
    len = {32'd0, s[0], s[1], s[2], s[3]};
    if (len > (64'd1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < int'(len); k++) begin
      logic [AW-1:0] a;
      if (4 + k >= s.size()) return;
      a = AW'(k);
      exp_wq.push_back({a, s[4+k]});
      x = x ^ s[4+k];
    end
`ifdef LOADER_CHECKSUM_EN
    if (4 + int'(len) >= s.size()) return;
    if (s[4+int'(len)] == x) exp_done = 1'b1;
    else                     exp_err  = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    wq.delete();
    done_cyc = -1;
    cpu_cyc  = -1;
    #1 rst_n = 1'b1;
  endtask

  task automatic feed(input string tag, input bq_t s, input int max_stall, input bit fixed);
    int budget;
    int n;
    foreach (s[i]) begin
      n = fixed ? max_stall : int'($urandom_range(max_stall, 0));
      repeat (n) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = s[i];
      budget   = 0;
      while (!rx_ready && !(done || err) && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (!rx_ready) begin
        if (budget >= 20) chk({tag, "/timeout"}, 64'(budget), 64'd0);
        rx_valid = 1'b0;
        break;
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
  endtask

  task automatic run_image(input string tag, input bq_t s, input int max_stall, input bit fixed);
    int n;
    run_model(s);
    feed(tag, s, max_stall, fixed);
    repeat (4) @(negedge clk);
    #1;
    chk({tag, "/nwr"}, 64'(wq.size()), 64'(exp_wq.size()));
    n = (wq.size() < exp_wq.size()) ? wq.size() : exp_wq.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s/wr%0d", tag, i), 64'(wq[i]), 64'(exp_wq[i]));
    chk({tag, "/done"}, 64'(done), 64'(exp_done));
    chk({tag, "/err"}, 64'(err), 64'(exp_err));
    chk({tag, "/cpu_rst_n"}, 64'(cpu_rst_n), 64'(exp_done));
    if (exp_done || exp_err) chk({tag, "/rx_ready"}, 64'(rx_ready), 64'd0);
    if (exp_done) chk({tag, "/cpu_delay"}, 64'(cpu_cyc - done_cyc), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/rx_ready"}, 64'(rx_ready), 64'd0);
    chk({tag, "/we"}, 64'(we), 64'd0);
    chk({tag, "/WA"}, 64'(WA), 64'd0);
    chk({tag, "/WD"}, 64'(WD), 64'd0);
    chk({tag, "/done"}, 64'(done), 64'd0);
    chk({tag, "/err"}, 64'(err), 64'd0);
    chk({tag, "/cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
  endtask

  function automatic bq_t make_image(input int len, input bit good_sum);
    bq_t q;
    logic [31:0] l;
    logic [7:0] x;
    logic [7:0] b;
    l = 32'(len);
    q = {l[31:24], l[23:16], l[15:8], l[7:0]};
    x = 8'h00;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      q.push_back(b);
      x = x ^ b;
    end
    q.push_back(good_sum ? x : (x ^ 8'h5A));
    q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t s;
    #12;
    chk_reset_outputs("reset");
    do_reset();

`ifdef LOADER_CHECKSUM_EN
    s = {8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
`else
    s = {8'h00, 8'h00, 8'h00, 8'h04, 8'h13, 8'h00, 8'h00, 8'h00};
`endif
    run_image("basic", s, 0, 1'b1);
    do_reset();
    run_image("stall3", s, 3, 1'b1);

    do_reset();
    s = {8'h00, 8'h10, 8'h00, 8'h01, 8'h11, 8'h22};
    run_image("toolong", s, 1, 1'b0);

    do_reset();
    s = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h77};
    run_image("len0", s, 1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    s = {8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'h55, 8'hFF};
    run_image("sum_ok", s, 1, 1'b0);
    do_reset();
    s = {8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'h55, 8'hFE};
    run_image("sum_bad", s, 1, 1'b0);
`endif

    // Abort after 2 of 4 payload bytes; reset must clear outputs without a clock edge.
    do_reset();
    s = {8'h00, 8'h00, 8'h00, 8'h04, 8'hC1, 8'hC2};
    feed("abort", s, 0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("abort_rst");
    wq.delete();
    done_cyc = -1;
    cpu_cyc  = -1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    run_image("reload", make_image(4, 1'b1), 1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      do_reset();
      run_image($sformatf("rand%0d", t),
                make_image(int'($urandom_range(12, 1)), 1'($urandom_range(1, 0))),
                2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
